// File: rtl/round_requant.sv
// round_requant: CH-lane signed requantiser. Each lane is arithmetic-right-shifted
// by a run-time amount, rounded (truncate / half-up / half-even / stochastic),
// then saturated to signed OUT_W. Two-stage pipeline with valid/ready on both sides.
// Ports: clk, rst_n (async, active-high); in_valid/in_ready/data_in/shift/mode
// (input beat); out_valid/out_ready/data_out/sat_out (output beat);
// sat_cnt/sat_clr (saturating count of lane saturations on delivered beats).
module round_requant #(
  parameter int          CH    = 2,
  parameter int          IN_W  = 32,
  parameter int          OUT_W = 8,
  parameter int          SH_W  = 5,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*IN_W-1:0]    data_in,
  input  logic [SH_W-1:0]       shift,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*OUT_W-1:0]   data_out,
  output logic [CH-1:0]         sat_out,
  output logic [15:0]           sat_cnt,
  input  logic                  sat_clr
);

  // One extra bit of headroom so x + 2^(s-1) can never wrap.
  localparam int RW = IN_W + 1;
  localparam logic signed [RW-1:0] MAX_R = $signed({{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [RW-1:0] MIN_R = $signed({{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

  // Per-lane seed; an all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [15:0] lane_seed(input int c);
    logic [15:0] v;
    v = SEED ^ 16'(c * 32'h9E37);
    return (v == 16'h0000) ? 16'h0001 : v;
  endfunction

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci, shift left, feedback into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  logic                  s1_valid_q, s1_valid_d;
  logic signed [RW-1:0]  r_q [CH];
  logic signed [RW-1:0]  r_d [CH];
  logic [15:0]           lfsr_q [CH];
  logic [15:0]           lfsr_d [CH];
  logic                  out_valid_q, out_valid_d;
  logic [CH*OUT_W-1:0]   data_out_q, data_out_d;
  logic [CH-1:0]         sat_out_q, sat_out_d;
  logic [15:0]           sat_cnt_q, sat_cnt_d;

  logic s1_en, s2_en, in_fire, out_fire;

  // No skid buffer: readiness ripples combinationally back from out_ready.
  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;
  assign in_fire  = in_valid && s1_en;
  assign out_fire = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign sat_out   = sat_out_q;
  assign sat_cnt   = sat_cnt_q;

  // Stage 1: shift and round each lane. The LFSR value seen here is the
  // pre-advance value for this beat.
  always_comb begin
    logic signed [RW-1:0] x_w, q_w, half_w, one_w, lsb_w, bump_w, rnd_w;
    logic [IN_W-1:0]      frac;
    logic [15:0]          a_al;
    int                   sh;
    x_w = '0; q_w = '0; half_w = '0; lsb_w = '0; bump_w = '0; rnd_w = '0;
    frac = '0; a_al = '0;
    one_w = $signed({{IN_W{1'b0}}, 1'b1});
    sh = int'(shift);
    s1_valid_d = s1_en ? in_valid : s1_valid_q;
    for (int c = 0; c < CH; c++) begin
      x_w    = $signed({data_in[c*IN_W + IN_W-1], data_in[c*IN_W +: IN_W]});
      q_w    = x_w >>> sh;
      half_w = $signed((one_w << sh) >> 1);
      lsb_w  = $signed({{IN_W{1'b0}}, q_w[0]});
      frac   = data_in[c*IN_W +: IN_W] & ~({IN_W{1'b1}} << sh);
      // Align the fraction so its MSB lands on bit 15 of the compare value.
      if (sh <= 16) a_al = 16'(frac << (16 - sh));
      else          a_al = 16'(frac >> (sh - 16));
      bump_w = $signed({{IN_W{1'b0}}, (lfsr_q[c] < a_al)});
      case (mode)
        2'd0:    rnd_w = q_w;
        2'd1:    rnd_w = (x_w + half_w) >>> sh;
        2'd2:    rnd_w = (x_w + half_w - one_w + lsb_w) >>> sh;
        default: rnd_w = q_w + bump_w;
      endcase
      if (sh == 0) rnd_w = x_w;
      r_d[c]    = r_q[c];
      lfsr_d[c] = lfsr_q[c];
      if (in_fire) begin
        r_d[c]    = rnd_w;
        lfsr_d[c] = lfsr_step(lfsr_q[c]);
      end
    end
  end

  // Stage 2: saturate to signed OUT_W and flag clipped lanes.
  always_comb begin
    out_valid_d = s2_en ? s1_valid_q : out_valid_q;
    data_out_d  = data_out_q;
    sat_out_d   = sat_out_q;
    if (s2_en && s1_valid_q) begin
      for (int c = 0; c < CH; c++) begin
        if (r_q[c] > MAX_R) begin
          data_out_d[c*OUT_W +: OUT_W] = {1'b0, {(OUT_W-1){1'b1}}};
          sat_out_d[c]                 = 1'b1;
        end else if (r_q[c] < MIN_R) begin
          data_out_d[c*OUT_W +: OUT_W] = {1'b1, {(OUT_W-1){1'b0}}};
          sat_out_d[c]                 = 1'b1;
        end else begin
          data_out_d[c*OUT_W +: OUT_W] = r_q[c][OUT_W-1:0];
          sat_out_d[c]                 = 1'b0;
        end
      end
    end
  end

  // Saturation event counter; a clear wins over that cycle's events.
  always_comb begin
    logic [16:0] pop, cnt_sum;
    pop = '0;
    for (int c = 0; c < CH; c++) pop = pop + 17'(sat_out_q[c]);
    cnt_sum   = {1'b0, sat_cnt_q} + pop;
    sat_cnt_d = sat_cnt_q;
    if (out_fire) sat_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    if (sat_clr)  sat_cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      sat_out_q   <= '0;
      sat_cnt_q   <= '0;
      for (int c = 0; c < CH; c++) begin
        r_q[c]    <= '0;
        lfsr_q[c] <= lane_seed(c);
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      sat_out_q   <= sat_out_d;
      sat_cnt_q   <= sat_cnt_d;
      for (int c = 0; c < CH; c++) begin
        r_q[c]    <= r_d[c];
        lfsr_q[c] <= lfsr_d[c];
      end
    end
  end

endmodule

// File: tb/tb_round_requant.sv
module tb_round_requant;
  localparam int          CH    = 2;
  localparam int          IN_W  = 32;
  localparam int          OUT_W = 8;
  localparam int          SH_W  = 5;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [CH*IN_W-1:0]  data_in = '0;
  logic [SH_W-1:0]     shift = '0;
  logic [1:0]          mode = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [CH*OUT_W-1:0] data_out;
  logic [CH-1:0]       sat_out;
  logic [15:0]         sat_cnt;
  logic                sat_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  round_requant #(.CH(CH), .IN_W(IN_W), .OUT_W(OUT_W), .SH_W(SH_W), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .shift(shift), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .sat_out(sat_out),
    .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_seed(input int c);
    logic [15:0] v;
    v = SEED ^ 16'(c * 32'h9E37);
    if (v == 16'h0000) v = 16'h0001;
    return v;
  endfunction

  function automatic logic [15:0] ref_next(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  // Rounding from first principles: floor quotient, remainder, then decide.
  function automatic longint ref_round(input longint x, input int s, input int md, input longint lv);
    longint d, q, fr, a;
    if (s == 0) return x;
    d = longint'(1) << s;
    q = x / d;
    if ((x % d != 0) && (x < 0)) q = q - 1;
    fr = x - q * d;
    case (md)
      0: return q;
      1: return (2 * fr >= d) ? q + 1 : q;
      2: begin
        if (2 * fr > d)       return q + 1;
        else if (2 * fr == d) return q + (q & 1);
        else                  return q;
      end
      default: begin
        a = (fr * 65536) / d;
        return (lv < a) ? q + 1 : q;
      end
    endcase
  endfunction

  logic [15:0]         m_lfsr [CH];
  logic [CH*OUT_W-1:0] exp_dat [$];
  logic [CH-1:0]       exp_sat [$];
  int                  m_cnt = 0;
  int                  acc_cnt = 0;
  bit                  stalled = 1'b0;
  logic [CH*OUT_W-1:0] prev_dat = '0;
  logic [CH-1:0]       prev_sat = '0;
  bit                  collect = 1'b0;
  longint              lane_sum [CH];

  initial for (int c = 0; c < CH; c++) lane_sum[c] = 0;

  // Monitor + scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic [CH*OUT_W-1:0] ed;
    logic [CH-1:0]       es;
    longint              r;
    if (rst_n) begin
      exp_dat.delete();
      exp_sat.delete();
      for (int c = 0; c < CH; c++) m_lfsr[c] = ref_seed(c);
      m_cnt   = 0;
      stalled = 1'b0;
    end else begin
      check("sat_cnt", 64'(sat_cnt), 64'(m_cnt));
      check("in_ready", 64'(in_ready), 64'((exp_dat.size() < 2) || out_ready));
      if (stalled) begin
        check("hold_vld", 64'(out_valid), 64'd1);
        check("hold_dat", 64'(data_out), 64'(prev_dat));
        check("hold_sat", 64'(sat_out), 64'(prev_sat));
      end
      if (out_valid && out_ready) begin
        check("beat_expected", 64'(exp_dat.size() > 0), 64'd1);
        if (exp_dat.size() > 0) begin
          ed = exp_dat.pop_front();
          es = exp_sat.pop_front();
          check("data", 64'(data_out), 64'(ed));
          check("sat", 64'(sat_out), 64'(es));
          if (collect)
            for (int c = 0; c < CH; c++)
              lane_sum[c] += longint'($signed(data_out[c*OUT_W +: OUT_W]));
          m_cnt = m_cnt + $countones(es);
          if (m_cnt > 65535) m_cnt = 65535;
        end
      end
      if (sat_clr) m_cnt = 0;
      if (in_valid && in_ready) begin
        check("shift_legal", 64'(int'(shift) < IN_W), 64'd1);
        for (int c = 0; c < CH; c++) begin
          r = ref_round(longint'($signed(data_in[c*IN_W +: IN_W])), int'(shift), int'(mode),
                        longint'(m_lfsr[c]));
          if (r > 127)       begin ed[c*OUT_W +: OUT_W] = 8'h7F;  es[c] = 1'b1; end
          else if (r < -128) begin ed[c*OUT_W +: OUT_W] = 8'h80;  es[c] = 1'b1; end
          else               begin ed[c*OUT_W +: OUT_W] = 8'(r);  es[c] = 1'b0; end
          m_lfsr[c] = ref_next(m_lfsr[c]);
        end
        exp_dat.push_back(ed);
        exp_sat.push_back(es);
        acc_cnt++;
      end
      stalled  = out_valid && !out_ready;
      prev_dat = data_out;
      prev_sat = sat_out;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic dir(input logic [31:0] x0, input logic [31:0] x1, input int sh, input int md,
                     input bit clr, output logic [15:0] o, output logic [1:0] s);
    data_in  = {x1, x0};
    shift    = SH_W'(sh);
    mode     = 2'(md);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat1_vld", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat2_vld", 64'(out_valid), 64'd1);
    o = data_out;
    s = sat_out;
    sat_clr = clr;
    @(posedge clk); #1;
    sat_clr = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] o;
    logic [1:0]  s;
    int          start;
    logic [31:0] x;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_data_out", 64'(data_out), 64'd0);
    check("reset_sat_out", 64'(sat_out), 64'd0);
    check("reset_sat_cnt", 64'(sat_cnt), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // 1.5 / 2.5 in the three deterministic modes
    dir(32'h180, 32'h280, 8, 0, 1'b0, o, s); check("m0_dat", 64'(o), 64'h0201); check("m0_sat", 64'(s), 64'd0);
    dir(32'h180, 32'h280, 8, 1, 1'b0, o, s); check("m1_dat", 64'(o), 64'h0302); check("m1_sat", 64'(s), 64'd0);
    dir(32'h180, 32'h280, 8, 2, 1'b0, o, s); check("m2_dat", 64'(o), 64'h0202); check("m2_sat", 64'(s), 64'd0);
    // -1.5
    dir(32'hFFFFFE80, 32'hFFFFFE80, 8, 0, 1'b0, o, s); check("neg_m0", 64'(o), 64'hFEFE);
    dir(32'hFFFFFE80, 32'hFFFFFE80, 8, 1, 1'b0, o, s); check("neg_m1", 64'(o), 64'hFFFF);
    dir(32'hFFFFFE80, 32'hFFFFFE80, 8, 2, 1'b0, o, s); check("neg_m2", 64'(o), 64'hFEFE);
    // saturation both directions, then the same beat with a clear
    dir(32'h7FFF0000, 32'h80000000, 8, 0, 1'b0, o, s);
    check("satv_dat", 64'(o), 64'h807F); check("satv_flag", 64'(s), 64'd3);
    check("satv_cnt", 64'(sat_cnt), 64'd2);
    dir(32'h7FFF0000, 32'h80000000, 8, 0, 1'b1, o, s);
    check("satclr_flag", 64'(s), 64'd3);
    check("satclr_cnt", 64'(sat_cnt), 64'd0);

    // Stochastic rounding from reset: constant 1.25, 4096 beats
    pulse_reset();
    data_in  = {32'h140, 32'h140};
    shift    = 5'd8;
    mode     = 2'd3;
    collect  = 1'b1;
    start    = acc_cnt;
    in_valid = 1'b1;
    repeat (4096) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    collect = 1'b0;
    check("mean_beats", 64'(acc_cnt - start), 64'd4096);
    for (int c = 0; c < CH; c++)
      check("mean_range", 64'((lane_sum[c] * 100 >= 503808) && (lane_sum[c] * 100 <= 520192)), 64'd1);

    // Random traffic with random backpressure
    start = acc_cnt;
    for (int cyc = 0; cyc < 20000 && (acc_cnt - start) < 1000; cyc++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      sat_clr   = ($urandom_range(0, 31) == 0);
      shift     = SH_W'($urandom_range(0, IN_W - 1));
      mode      = 2'($urandom_range(0, 3));
      for (int c = 0; c < CH; c++) begin
        case ($urandom_range(0, 2))
          0:       x = $urandom;
          1:       x = 32'($signed(16'($urandom)));
          default: x = 32'($urandom_range(0, 1023));
        endcase
        data_in[c*IN_W +: IN_W] = x;
      end
    end
    check("rand_beats", 64'((acc_cnt - start) >= 1000), 64'd1);
    in_valid  = 1'b0;
    sat_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rand_drained", 64'(exp_dat.size()), 64'd0);

    // Fill both stages, then reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mode      = 2'd3;
    shift     = 5'd4;
    data_in   = {32'h7, 32'h9};
    repeat (3) @(posedge clk);
    #1;
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    pulse_reset();
    out_ready = 1'b1;
    @(posedge clk); #1;
    // lane 0 seed 0xACE1 < 0xACE2 rounds up; lane 1 seed 0x32D6 is not < 0x32D6
    dir(32'h0000ACE2, 32'h000032D6, 16, 3, 1'b0, o, s);
    check("seed_beat", 64'(o), 64'h0001);
    repeat (3) @(posedge clk);
    #1;
    check("final_drained", 64'(exp_dat.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_requant.md
# round_requant

Parametrised multi-channel requantiser. It takes CH signed IN_W-bit accumulator lanes, right-shifts each lane by a run-time amount, and rounds using one of four modes: truncate, round-half-up, round-half-even or stochastic. Each lane is then saturated to signed OUT_W. It sits between the PE-array accumulators and the activation writeback path, and replaces the fixed two-lane 32→8 stochastic rounder. It adds a valid/ready handshake, run-time mode and shift, and per-lane saturation reporting.

## Interface
- CH, 2, number of parallel lanes
- IN_W, 32, input lane width (signed)
- OUT_W, 8, output lane width (signed), OUT_W < IN_W
- SH_W, 5, shift field width; legal shift 0..IN_W-1
- SEED, 16'hACE1, base LFSR seed
- Reset is rst_n: asynchronous, active-high. Clock is clk.
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- data_in  in  CH*IN_W  lane c at [c*IN_W +: IN_W]
- shift  in  SH_W  right-shift amount, sampled with the beat
- mode  in  2  0 truncate(floor), 1 half-up, 2 half-even, 3 stochastic; sampled with the beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- data_out  out  CH*OUT_W  lane c at [c*OUT_W +: OUT_W]
- sat_out  out  CH  per-lane saturation flag, aligned with data_out
- sat_cnt  out  16  saturating count of lane-saturation events on accepted output beats
- sat_clr  in  1  synchronous clear of sat_cnt

## Operation
- Per lane, x is signed IN_W and s = shift. Let F = x[s-1:0] be the fraction bits and q = x >>> s (arithmetic shift). All intermediate arithmetic is IN_W+1 bits, so no overflow is possible.
- If s = 0, the rounding result r = x in every mode.
- mode 0: r = q.
- mode 1: r = (x + 2^(s-1)) >>> s.
- mode 2: r = (x + 2^(s-1) - 1 + q[0]) >>> s, so exact ties go to even.
- mode 3: r = q + (L < A), where A is F aligned to 16 bits:
  - for s ≤ 16, A = F << (16-s);
  - for s > 16, A = F[s-1 -: 16].
  - L is the lane's current LFSR value, compared unsigned.
- Saturation:
  - r > 2^(OUT_W-1)-1 → output 2^(OUT_W-1)-1 and sat_out[c] = 1;
  - r < -2^(OUT_W-1) → output -2^(OUT_W-1) and sat_out[c] = 1;
  - otherwise output r[OUT_W-1:0] and sat_out[c] = 0.
- LFSRs: one 16-bit Fibonacci LFSR per lane, polynomial x^16+x^14+x^13+x^11+1, shifting left with the feedback bit into bit 0.
  - Lane c seed is SEED ^ (c*16'h9E37); if the result is 0, the seed is 16'h0001.
  - An LFSR advances exactly once per accepted input beat (in_valid & in_ready), in every mode. It holds otherwise.
  - The LFSR value used for a beat is the value before that beat's advance.
- sat_cnt: on each accepted output beat (out_valid & out_ready) it adds popcount(sat_out) and saturates at 16'hFFFF.
  - sat_clr has priority: sat_cnt goes to 0 that cycle and that beat's events are dropped.
- Shift values ≥ IN_W are illegal and the result is undefined. Bench asserts shift < IN_W on accepted beats.

## Timing
- Two-stage pipeline:
  - S1 registers the rounded r (IN_W+1 bits) per lane.
  - S2 registers the saturated data_out and sat_out.
- Latency is 2 cycles from accept to out_valid when there is no backpressure. Throughput is 1 beat per cycle.
- Stage enables:
  - s2_en = !out_valid | out_ready
  - s1_en = !s1_valid | s2_en
  - in_ready = s1_en, which is combinational from out_ready. There is no skid buffer.
- While out_valid=1 and out_ready=0, data_out, sat_out and out_valid hold stable, and S1 holds if it is full.
- Reset (asynchronous, any cycle including mid-stream):
  - s1_valid, out_valid, data_out, sat_out and sat_cnt go to 0;
  - LFSRs return to their seeds;
  - in-flight beats are discarded;
  - in_ready = 1 after reset.
- A beat is accepted and a beat delivered in the same cycle when both handshakes fire; no bubble is inserted.

## Test plan
- CH=2, shift=8, in=0x00000180 / 0x00000280 in modes 0, 1, 2 → out 1/2, 2/3, 2/2; sat_out=0; out_valid 2 cycles after accept.
- shift=8, in=0xFFFFFE80 (-1.5) → mode0 -2 (0xFE), mode1 -1 (0xFF), mode2 -2 (0xFE).
- in=0x7FFF0000 and 0x80000000 with shift=8, out_ready=1 → 0x7F and 0x80, sat_out=2'b11, sat_cnt increments by 2; asserting sat_clr on the same beat → sat_cnt=0.
- Mode 3, shift=8, constant in=0x00000140 (1.25) for 4096 beats → mean output 1.25±0.02. Lane sequences match a reference LFSR model bit-exactly from reset.
- Random out_ready (50%) with random in_valid over 1000 beats → no beat lost or duplicated, ordering preserved, outputs stable while stalled, LFSR advanced exactly once per accepted beat.
- Assert rst_n for 1 cycle while both stages are full → out_valid=0 and sat_cnt=0 immediately. The next beat uses seed-value LFSRs.
